btn_debounce: RTL

- Front end for the player-ship movement logic.
- Synchronizes and debounces the four raw direction buttons, and produces the 10 ms movement tick.
- Drives the debounced level vector `btnstate[3:0]`, which the ship-position block consumes on each 10 ms tick.
- Also emits one-cycle press pulses for menu and restart logic.

---
 rtl/btn_debounce.sv | 95 +++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchronizer, 10 ms tick divider, per-button
// tick-sampled debounce and one-cycle press pulses.
module btn_debounce #(
  parameter int unsigned CLK_DIV    = 500000,
  parameter int unsigned DEB_TICKS  = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic       tick_10ms,
  output logic [3:0] btnstate,
  output logic [3:0] btnpress
);

  localparam int unsigned NBTN  = 4;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DC_W  = $clog2(DEB_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEB_TICKS - 1);
  localparam logic [DC_W-1:0]  DC_ONE   = DC_W'(1);

  logic [NBTN-1:0]  w_pressed;
  logic [NBTN-1:0]  r_sync1;
  logic [NBTN-1:0]  r_sync2;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [DC_W-1:0]  r_dc [NBTN];
  logic [DC_W-1:0]  w_dc_nxt [NBTN];
  logic [NBTN-1:0]  w_state_nxt;

  // Normalise polarity so 1 always means pressed, including the reset value.
  assign w_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pressed;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running divider; the last count is the internal tick condition.
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      tick_10ms <= 1'b0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      tick_10ms <= w_tick;
    end
  end

  // A differing sample must be seen on DEB_TICKS consecutive ticks to flip.
  always_comb begin
    w_state_nxt = btnstate;
    for (int i = 0; i < NBTN; i++) begin
      w_dc_nxt[i] = r_dc[i];
    end
    if (w_tick) begin
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == btnstate[i]) begin
          w_dc_nxt[i] = '0;
        end else if (r_dc[i] == DC_LAST) begin
          w_state_nxt[i] = r_sync2[i];
          w_dc_nxt[i]    = '0;
        end else begin
          w_dc_nxt[i] = r_dc[i] + DC_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btnstate <= '0;
      btnpress <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_dc[i] <= '0;
      end
    end else begin
      btnstate <= w_state_nxt;
      btnpress <= w_state_nxt & ~btnstate;
      for (int i = 0; i < NBTN; i++) begin
        r_dc[i] <= w_dc_nxt[i];
      end
    end
  end

endmodule
